mem_arbiter: RTL and testbench

//   Shares the single DPI memory port (men/mwen/raddr/waddr/wdata/wmask/rdata)

---
 rtl/mem_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory port between an instruction-fetch (IF) read requester
//   and a load/store (LS) read/write requester. Every access is sequenced as
//   IDLE -> [WAIT x LATENCY] -> ACCESS -> RESP so that men is a registered,
//   glitch-free pulse lasting exactly one cycle. The memory model performs a
//   write on every cycle where men && mwen, so this pulse shape is essential.
//
// Ports
//   clk, rst               clock (posedge) and asynchronous active-high reset
//   if_req/if_addr         IF read request, held until if_gnt
//   if_gnt                 IF request accepted (combinational, IDLE only)
//   if_rvalid/if_rdata     one-cycle IF read response
//   ls_req/ls_we/ls_addr/  LS request and payload, held until ls_gnt
//   ls_wdata/ls_wmask
//   ls_gnt                 LS request accepted (combinational, IDLE only)
//   ls_rvalid/ls_rdata     one-cycle LS response (rdata is 0 for writes)
//   men/mwen               registered memory enable / write enable
//   raddr/waddr            captured access address
//   wdata/wmask            captured write data / byte mask (mask 0 on reads)
//   rdata                  memory read data, combinational from men/raddr
module mem_arbiter #(
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int MW      = 8,
  parameter int LATENCY = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  input  logic [MW-1:0] ls_wmask,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [DW-1:0] ls_rdata,
  output logic          men,
  output logic          mwen,
  output logic [AW-1:0] raddr,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic [MW-1:0] wmask,
  input  logic [DW-1:0] rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [3:0] LAT      = 4'(LATENCY);
  localparam logic       OWNER_IF = 1'b0;
  localparam logic       OWNER_LS = 1'b1;

  state_t        state;
  state_t        state_d;
  logic [3:0]    cnt;
  logic          last_grant;
  logic          owner;
  logic          cap_we;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata;
  logic [MW-1:0] cap_wmask;
  logic [DW-1:0] resp_data;

  logic          pick_if;
  logic          pick_ls;
  logic          grant;
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic [MW-1:0] acc_wmask;

  // Round-robin pick, only in IDLE. Under contention the requester that did
  // not win last time is chosen. Gated by rst so both grants stay low while
  // reset is asserted.
  always_comb begin
    pick_if = 1'b0;
    pick_ls = 1'b0;
    if (state == IDLE && !rst) begin
      if (if_req && (!ls_req || last_grant == OWNER_LS)) begin
        pick_if = 1'b1;
      end else if (ls_req) begin
        pick_ls = 1'b1;
      end
    end
  end

  assign grant  = pick_if | pick_ls;
  assign if_gnt = pick_if;
  assign ls_gnt = pick_ls;

  // Access payload: taken live from the winner on the grant cycle (needed
  // when LATENCY is 0 and ACCESS follows IDLE directly), else from the
  // captured copy. Reads always carry a zero byte mask.
  always_comb begin
    if (state == IDLE) begin
      acc_we    = pick_ls & ls_we;
      acc_addr  = pick_ls ? ls_addr : if_addr;
      acc_wdata = pick_ls ? ls_wdata : '0;
      acc_wmask = (pick_ls && ls_we) ? ls_wmask : '0;
    end else begin
      acc_we    = cap_we;
      acc_addr  = cap_addr;
      acc_wdata = cap_wdata;
      acc_wmask = cap_wmask;
    end
  end

  // Next-state logic. WAIT leaves when the counter shows 1, which yields
  // exactly LATENCY wait cycles because it was loaded with LATENCY.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (grant) state_d = (LAT != 4'd0) ? WAIT : ACCESS;
      WAIT:    if (cnt == 4'd1) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Capture the granted request and run the wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 4'd0;
      last_grant <= OWNER_LS;
      owner      <= OWNER_IF;
      cap_we     <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_wmask  <= '0;
    end else begin
      if (grant) begin
        cnt        <= LAT;
        last_grant <= pick_ls;
        owner      <= pick_ls;
        cap_we     <= acc_we;
        cap_addr   <= acc_addr;
        cap_wdata  <= acc_wdata;
        cap_wmask  <= acc_wmask;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Memory port registers. men/mwen are high only for the single cycle the
  // FSM spends in ACCESS; address/data only change on entry to ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      men   <= 1'b0;
      mwen  <= 1'b0;
      raddr <= '0;
      waddr <= '0;
      wdata <= '0;
      wmask <= '0;
    end else begin
      men  <= (state_d == ACCESS);
      mwen <= (state_d == ACCESS) && acc_we;
      if (state_d == ACCESS) begin
        raddr <= acc_addr;
        waddr <= acc_addr;
        wdata <= acc_wdata;
        wmask <= acc_wmask;
      end
    end
  end

  // Response: sample memory data at the end of ACCESS and pulse the owner's
  // rvalid during RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_data <= '0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
    end else begin
      if_rvalid <= (state == ACCESS) && (owner == OWNER_IF);
      ls_rvalid <= (state == ACCESS) && (owner == OWNER_LS);
      if (state == ACCESS) begin
        resp_data <= cap_we ? '0 : rdata;
      end
    end
  end

  assign if_rdata = resp_data;
  assign ls_rdata = resp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Two arbiters: index 0 built with LATENCY=0, index 1 with LATENCY=3.
//   A small 16-word memory per arbiter stands in for the DPI model.
module tb_mem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]         if_req, if_gnt, if_rvalid;
  logic [1:0]         ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [1:0]         men, mwen;
  logic [1:0][AW-1:0] if_addr, ls_addr, raddr, waddr;
  logic [1:0][DW-1:0] if_rdata, ls_wdata, ls_rdata, wdata, rdata;
  logic [1:0][MW-1:0] ls_wmask, wmask;

  mem_arbiter #(.AW(AW), .DW(DW), .MW(MW), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
    .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
    .ls_req(ls_req[0]), .ls_we(ls_we[0]), .ls_addr(ls_addr[0]),
    .ls_wdata(ls_wdata[0]), .ls_wmask(ls_wmask[0]), .ls_gnt(ls_gnt[0]),
    .ls_rvalid(ls_rvalid[0]), .ls_rdata(ls_rdata[0]),
    .men(men[0]), .mwen(mwen[0]), .raddr(raddr[0]), .waddr(waddr[0]),
    .wdata(wdata[0]), .wmask(wmask[0]), .rdata(rdata[0])
  );

  mem_arbiter #(.AW(AW), .DW(DW), .MW(MW), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
    .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
    .ls_req(ls_req[1]), .ls_we(ls_we[1]), .ls_addr(ls_addr[1]),
    .ls_wdata(ls_wdata[1]), .ls_wmask(ls_wmask[1]), .ls_gnt(ls_gnt[1]),
    .ls_rvalid(ls_rvalid[1]), .ls_rdata(ls_rdata[1]),
    .men(men[1]), .mwen(mwen[1]), .raddr(raddr[1]), .waddr(waddr[1]),
    .wdata(wdata[1]), .wmask(wmask[1]), .rdata(rdata[1])
  );

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [7:0]  m);
    logic [63:0] r;
    r = old_v;
    for (int b = 0; b < 8; b++) if (m[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  // Memory stand-in: combinational read while men is high, byte-masked write
  // on every edge where men && mwen, plus a write counter. Preload is done
  // by this same process so only one process ever writes the memory.
  logic [63:0] mem_arr      [2][16];
  logic [63:0] preload_vals [2][16];
  logic [63:0] ref_mem      [2][16];
  bit          do_preload = 1'b0;
  int          wr_count [2] = '{0, 0};

  assign rdata[0] = men[0] ? mem_arr[0][raddr[0][6:3]] : '0;
  assign rdata[1] = men[1] ? mem_arr[1][raddr[1][6:3]] : '0;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (do_preload) begin
        for (int i = 0; i < 16; i++) mem_arr[d][i] <= preload_vals[d][i];
      end else if (men[d] && mwen[d]) begin
        mem_arr[d][waddr[d][6:3]] <= merge_bytes(mem_arr[d][waddr[d][6:3]], wdata[d], wmask[d]);
        wr_count[d] <= wr_count[d] + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reset both arbiters with requests held high; every output must stay 0.
  task automatic do_reset();
    rst = 1'b1;
    if_req = 2'b11; ls_req = 2'b11; ls_we = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput("rst_if_gnt", if_gnt[d], 0);
      checkOutput("rst_ls_gnt", ls_gnt[d], 0);
      checkOutput("rst_men", men[d], 0);
      checkOutput("rst_mwen", mwen[d], 0);
      checkOutput("rst_if_rvalid", if_rvalid[d], 0);
      checkOutput("rst_ls_rvalid", ls_rvalid[d], 0);
      checkOutput("rst_raddr", raddr[d], 0);
      checkOutput("rst_wmask", wmask[d], 0);
      checkOutput("rst_ls_rdata", ls_rdata[d], 0);
    end
    if_req = '0; ls_req = '0; ls_we = '0;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic preload_mem();
    do_preload = 1'b1;
    next_cycle();
    do_preload = 1'b0;
  endtask

  typedef struct {
    bit          is_ls;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] exp_rdata;
  } vec_t;

  // One complete access on the LATENCY=0 arbiter: grant in cycle 0,
  // memory pulse in cycle 1, response in cycle 2, quiet in cycle 3.
  task automatic applyStimulus(input vec_t v);
    if (v.is_ls) begin
      ls_req[0] = 1'b1; ls_we[0] = v.we; ls_addr[0] = v.addr;
      ls_wdata[0] = v.wdata; ls_wmask[0] = v.wmask;
    end else begin
      if_req[0] = 1'b1; if_addr[0] = v.addr;
    end
    @(negedge clk);
    checkOutput("v_if_gnt", if_gnt[0], !v.is_ls);
    checkOutput("v_ls_gnt", ls_gnt[0], v.is_ls);
    checkOutput("v_men_c0", men[0], 0);
    next_cycle();
    if_req[0] = 1'b0; ls_req[0] = 1'b0;
    @(negedge clk);
    checkOutput("v_men_c1", men[0], 1);
    checkOutput("v_mwen_c1", mwen[0], v.we);
    checkOutput("v_raddr", raddr[0], v.addr);
    checkOutput("v_waddr", waddr[0], v.addr);
    checkOutput("v_wmask", wmask[0], v.we ? v.wmask : 8'h00);
    if (v.we) checkOutput("v_wdata", wdata[0], v.wdata);
    checkOutput("v_rvalid_c1", if_rvalid[0] | ls_rvalid[0], 0);
    next_cycle();
    @(negedge clk);
    checkOutput("v_men_c2", men[0], 0);
    checkOutput("v_if_rvalid", if_rvalid[0], !v.is_ls);
    checkOutput("v_ls_rvalid", ls_rvalid[0], v.is_ls);
    checkOutput("v_rdata", v.is_ls ? ls_rdata[0] : if_rdata[0], v.exp_rdata);
    next_cycle();
    @(negedge clk);
    checkOutput("v_rvalid_c3", if_rvalid[0] | ls_rvalid[0], 0);
    checkOutput("v_men_c3", men[0], 0);
    next_cycle();
  endtask

  function automatic logic [63:0] rand_addr();
    return 64'h8000_0000 + 64'($urandom_range(0, 15)) * 64'd8;
  endfunction

  // Transaction-level reference: a grant in cycle n makes the arbiter busy
  // until n+L+3, fires men at n+L+1 and answers at n+L+2. Memory contents
  // are tracked in ref_mem in grant order.
  int  lat_of [2] = '{0, 3};
  int  free_at [2];
  int  men_at [2];
  int  rv_at [2];
  bit  last_ls [2];
  bit  t_owner_ls [2];
  bit  t_we [2];
  logic [63:0] t_addr [2];
  logic [63:0] t_wdata [2];
  logic [63:0] t_exp [2];
  logic [7:0]  t_wmask [2];
  bit  seen_if_gnt [2];
  bit  seen_ls_gnt [2];

  task automatic random_phase(input int ncycles);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        preload_vals[d][i] = {$urandom, $urandom};
        ref_mem[d][i] = preload_vals[d][i];
      end
      free_at[d] = 0; men_at[d] = -1; rv_at[d] = -1; last_ls[d] = 1'b1;
      seen_if_gnt[d] = 1'b0; seen_ls_gnt[d] = 1'b0;
    end
    preload_mem();
    for (int n = 0; n < ncycles; n++) begin
      for (int d = 0; d < 2; d++) begin
        if (if_req[d]) begin
          if (seen_if_gnt[d]) begin
            if ($urandom_range(0, 1) == 1) if_addr[d] = rand_addr();
            else if_req[d] = 1'b0;
          end else if ($urandom_range(0, 19) == 0) begin
            if_req[d] = 1'b0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          if_req[d] = 1'b1; if_addr[d] = rand_addr();
        end
        if (ls_req[d] && !seen_ls_gnt[d]) begin
          if ($urandom_range(0, 19) == 0) ls_req[d] = 1'b0;
        end else if (ls_req[d] || $urandom_range(0, 3) == 0) begin
          ls_req[d] = ($urandom_range(0, 2) != 0);
          ls_we[d] = 1'($urandom_range(0, 1));
          ls_addr[d] = rand_addr();
          ls_wdata[d] = {$urandom, $urandom};
          ls_wmask[d] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        end
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        bit exp_ig, exp_lg, em;
        int idx;
        exp_ig = 1'b0; exp_lg = 1'b0;
        if (n >= free_at[d]) begin
          if (if_req[d] && (!ls_req[d] || last_ls[d])) exp_ig = 1'b1;
          else if (ls_req[d]) exp_lg = 1'b1;
        end
        checkOutput("rnd_if_gnt", if_gnt[d], exp_ig);
        checkOutput("rnd_ls_gnt", ls_gnt[d], exp_lg);
        seen_if_gnt[d] = if_gnt[d];
        seen_ls_gnt[d] = ls_gnt[d];
        if (exp_ig || exp_lg) begin
          last_ls[d] = exp_lg;
          t_owner_ls[d] = exp_lg;
          t_we[d] = exp_lg && ls_we[d];
          t_addr[d] = exp_lg ? ls_addr[d] : if_addr[d];
          t_wdata[d] = ls_wdata[d];
          t_wmask[d] = t_we[d] ? ls_wmask[d] : 8'h00;
          idx = int'(t_addr[d][6:3]);
          if (t_we[d]) begin
            ref_mem[d][idx] = merge_bytes(ref_mem[d][idx], t_wdata[d], t_wmask[d]);
            t_exp[d] = '0;
          end else begin
            t_exp[d] = ref_mem[d][idx];
          end
          men_at[d] = n + lat_of[d] + 1;
          rv_at[d] = n + lat_of[d] + 2;
          free_at[d] = n + lat_of[d] + 3;
        end
        em = (n == men_at[d]);
        checkOutput("rnd_men", men[d], em);
        checkOutput("rnd_write", men[d] & mwen[d], em & t_we[d]);
        if (em) begin
          checkOutput("rnd_raddr", raddr[d], t_addr[d]);
          checkOutput("rnd_waddr", waddr[d], t_addr[d]);
          checkOutput("rnd_wmask", wmask[d], t_wmask[d]);
          if (t_we[d]) checkOutput("rnd_wdata", wdata[d], t_wdata[d]);
        end
        checkOutput("rnd_if_rvalid", if_rvalid[d], (n == rv_at[d]) && !t_owner_ls[d]);
        checkOutput("rnd_ls_rvalid", ls_rvalid[d], (n == rv_at[d]) && t_owner_ls[d]);
        if (n == rv_at[d]) checkOutput("rnd_rdata", t_owner_ls[d] ? ls_rdata[d] : if_rdata[d], t_exp[d]);
      end
      next_cycle();
    end
    if_req = '0; ls_req = '0;
    repeat (8) next_cycle();
  endtask

  vec_t table_v [6];

  initial begin
    int wc;
    int order [$];

    // Directed vectors for the LATENCY=0 arbiter, evaluated against the
    // preloaded memory contents below.
    table_v[0] = '{0, 0, 64'h8000_0000, 64'h0, 8'h00, 64'h1122_3344_5566_7788};
    table_v[1] = '{1, 1, 64'h8000_0010, 64'h0000_0000_DEAD_BEEF, 8'h0F, 64'h0};
    table_v[2] = '{1, 0, 64'h8000_0010, 64'h0, 8'h00, 64'hAAAA_BBBB_DEAD_BEEF};
    table_v[3] = '{1, 1, 64'h8000_0018, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'h0};
    table_v[4] = '{0, 0, 64'h8000_0018, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF};
    table_v[5] = '{1, 0, 64'h8000_0000, 64'h0, 8'h00, 64'h1122_3344_5566_7788};

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) preload_vals[d][i] = 64'(i) * 64'h0101_0101_0101_0101;
    preload_vals[0][0] = 64'h1122_3344_5566_7788;
    preload_vals[0][2] = 64'hAAAA_BBBB_CCCC_DDDD;
    preload_vals[0][3] = 64'h0123_4567_89AB_CDEF;
    preload_vals[0][4] = 64'h0F0F_0F0F_F0F0_F0F0;
    preload_vals[1][1] = 64'hCAFE_F00D_1234_5678;

    if_req = '0; ls_req = '0; ls_we = '0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;

    do_reset();
    preload_mem();
    for (int i = 0; i < 6; i++) applyStimulus(table_v[i]);

    // Contention out of reset: both held high, grants must alternate IF first.
    do_reset();
    if_req[0] = 1'b1; if_addr[0] = 64'h8000_0000;
    ls_req[0] = 1'b1; ls_we[0] = 1'b0; ls_addr[0] = 64'h8000_0018;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      @(negedge clk);
      checkOutput("rr_both_gnt", if_gnt[0] & ls_gnt[0], 0);
      checkOutput("rr_both_rvalid", if_rvalid[0] & ls_rvalid[0], 0);
      if (if_gnt[0]) order.push_back(0);
      if (ls_gnt[0]) order.push_back(1);
      next_cycle();
    end
    if_req[0] = 1'b0; ls_req[0] = 1'b0;
    repeat (3) next_cycle();
    checkOutput("rr_grant_count", order.size(), 4);
    for (int i = 0; i < 4; i++) begin
      int want;
      want = i % 2;
      checkOutput("rr_order", (i < order.size()) ? order[i] : -1, want);
    end

    // LATENCY=3 single LS read: three silent WAIT cycles, men at cycle 4,
    // response at cycle 5.
    ls_req[1] = 1'b1; ls_we[1] = 1'b0; ls_addr[1] = 64'h8000_0008;
    @(negedge clk);
    checkOutput("lat3_gnt", ls_gnt[1], 1);
    next_cycle();
    ls_req[1] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checkOutput("lat3_wait_men", men[1], 0);
      checkOutput("lat3_wait_rvalid", ls_rvalid[1], 0);
      next_cycle();
    end
    @(negedge clk);
    checkOutput("lat3_men_c4", men[1], 1);
    checkOutput("lat3_mwen_c4", mwen[1], 0);
    checkOutput("lat3_raddr", raddr[1], 64'h8000_0008);
    next_cycle();
    @(negedge clk);
    checkOutput("lat3_men_c5", men[1], 0);
    checkOutput("lat3_rvalid_c5", ls_rvalid[1], 1);
    checkOutput("lat3_rdata", ls_rdata[1], 64'hCAFE_F00D_1234_5678);
    next_cycle();
    @(negedge clk);
    checkOutput("lat3_rvalid_c6", ls_rvalid[1], 0);
    next_cycle();

    // LS request raised while IF is in flight and dropped before IDLE:
    // it must leave no trace.
    wc = wr_count[0];
    if_req[0] = 1'b1; if_addr[0] = 64'h8000_0018;
    @(negedge clk);
    checkOutput("drop_if_gnt", if_gnt[0], 1);
    next_cycle();
    if_req[0] = 1'b0;
    ls_req[0] = 1'b1; ls_we[0] = 1'b1; ls_addr[0] = 64'h8000_0028;
    ls_wdata[0] = 64'h1234; ls_wmask[0] = 8'hFF;
    @(negedge clk);
    checkOutput("drop_ls_gnt_c1", ls_gnt[0], 0);
    checkOutput("drop_men_c1", men[0], 1);
    next_cycle();
    @(negedge clk);
    checkOutput("drop_ls_gnt_c2", ls_gnt[0], 0);
    checkOutput("drop_if_rvalid", if_rvalid[0], 1);
    checkOutput("drop_if_rdata", if_rdata[0], 64'h0123_4567_89AB_CDEF);
    next_cycle();
    ls_req[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("drop_ls_gnt_late", ls_gnt[0], 0);
      checkOutput("drop_men_late", men[0], 0);
      checkOutput("drop_ls_rvalid", ls_rvalid[0], 0);
      next_cycle();
    end
    checkOutput("drop_wr_count", wr_count[0], wc);

    // Reset during the ACCESS cycle of a write: pulse dies at once, no write,
    // no response, and the next request is served normally.
    wc = wr_count[0];
    ls_req[0] = 1'b1; ls_we[0] = 1'b1; ls_addr[0] = 64'h8000_0020;
    ls_wdata[0] = 64'h5555_5555_5555_5555; ls_wmask[0] = 8'hFF;
    @(negedge clk);
    checkOutput("rstmid_gnt", ls_gnt[0], 1);
    next_cycle();
    ls_req[0] = 1'b0;
    @(negedge clk);
    checkOutput("rstmid_men_before", men[0], 1);
    checkOutput("rstmid_mwen_before", mwen[0], 1);
    #1 rst = 1'b1;
    #1;
    checkOutput("rstmid_men_async", men[0], 0);
    checkOutput("rstmid_mwen_async", mwen[0], 0);
    next_cycle();
    checkOutput("rstmid_rvalid_in_rst", ls_rvalid[0], 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("rstmid_men_after", men[0], 0);
      checkOutput("rstmid_rvalid_after", ls_rvalid[0], 0);
      next_cycle();
    end
    checkOutput("rstmid_wr_count", wr_count[0], wc);
    checkOutput("rstmid_mem_kept", mem_arr[0][4], 64'h0F0F_0F0F_F0F0_F0F0);
    applyStimulus('{1, 0, 64'h8000_0020, 64'h0, 8'h00, 64'h0F0F_0F0F_F0F0_F0F0});

    // Randomized traffic on both arbiters against the reference model.
    do_reset();
    random_phase(2500);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
